// File: rtl/align_shifter_if.sv
// Handshake bundle for the alignment right-shifter.
// Carries operand, shift amount, tag and result fields.
interface align_shifter_if #(
    parameter int DataWidth = 24,
    parameter int MaxShift  = 26,
    parameter int TagWidth  = 4
);
    localparam int ShiftWidth = $clog2(MaxShift + 1);

    logic                  valid_i;
    logic                  ready_o;
    logic [DataWidth-1:0]  data_i;
    logic [ShiftWidth-1:0] shift_amount_i;
    logic [TagWidth-1:0]   tag_i;
    logic                  valid_o;
    logic                  ready_i;
    logic [DataWidth-1:0]  data_o;
    logic                  guard_o;
    logic                  round_o;
    logic                  sticky_o;
    logic [TagWidth-1:0]   tag_o;

    modport slave (
        input  valid_i, data_i, shift_amount_i, tag_i, ready_i,
        output ready_o, valid_o, data_o, guard_o, round_o,
        output sticky_o, tag_o
    );

    modport master (
        output valid_i, data_i, shift_amount_i, tag_i, ready_i,
        input  ready_o, valid_o, data_o, guard_o, round_o,
        input  sticky_o, tag_o
    );
endinterface

// File: rtl/align_shifter.sv
// Pipelined significand right-shifter for FP add alignment.
// One stage per shift bit; low bits fold into sticky.
module align_shifter #(
    parameter int DataWidth = 24,
    parameter int MaxShift  = 26,
    parameter int TagWidth  = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    align_shifter_if.slave bus
);
    localparam int W          = DataWidth + 2;
    localparam int ShiftWidth = $clog2(MaxShift + 1);
    localparam logic [ShiftWidth-1:0] MaxSh = ShiftWidth'(MaxShift);

    logic [W-1:0]          r_v   [ShiftWidth];
    logic                  r_s   [ShiftWidth];
    logic [ShiftWidth-1:0] r_sh  [ShiftWidth];
    logic [TagWidth-1:0]   r_tag [ShiftWidth];
    logic                  r_vld [ShiftWidth];

    logic [W-1:0]          w_nv   [ShiftWidth];
    logic                  w_ns   [ShiftWidth];
    logic [ShiftWidth-1:0] w_nsh  [ShiftWidth];
    logic [TagWidth-1:0]   w_ntag [ShiftWidth];
    logic                  w_nvld [ShiftWidth];

    logic                  w_adv;
    logic [ShiftWidth-1:0] w_sh_clamp;

    // OR of the n lowest bits of v (bits about to leave the vector)
    function automatic logic low_or(input logic [W-1:0] v, input int n);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i < n) acc = acc | v[i];
        end
        return acc;
    endfunction

    // whole pipe moves unless a finished result is blocked downstream
    assign w_adv       = bus.ready_i || !r_vld[ShiftWidth-1];
    assign bus.ready_o = w_adv;

    // saturate oversize shifts so everything lands in sticky
    always_comb begin
        w_sh_clamp = bus.shift_amount_i;
        if (bus.shift_amount_i > MaxSh) w_sh_clamp = MaxSh;
    end

    // per-stage next value: take predecessor, apply shift by 2^k if bit k set
    always_comb begin
        for (int k = 0; k < ShiftWidth; k++) begin
            if (k == 0) begin
                w_nv[k]   = {bus.data_i, 2'b00};
                w_ns[k]   = 1'b0;
                w_nsh[k]  = w_sh_clamp;
                w_ntag[k] = bus.tag_i;
                w_nvld[k] = bus.valid_i && w_adv;
            end else begin
                w_nv[k]   = r_v[(k > 0) ? k - 1 : 0];
                w_ns[k]   = r_s[(k > 0) ? k - 1 : 0];
                w_nsh[k]  = r_sh[(k > 0) ? k - 1 : 0];
                w_ntag[k] = r_tag[(k > 0) ? k - 1 : 0];
                w_nvld[k] = r_vld[(k > 0) ? k - 1 : 0];
            end
            if (w_nsh[k][k]) begin
                w_ns[k] = w_ns[k] | low_or(w_nv[k], 2 ** k);
                w_nv[k] = w_nv[k] >> (2 ** k);
            end
        end
    end

    // stage registers; all hold together on a downstream stall
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < ShiftWidth; k++) begin
                r_v[k]   <= '0;
                r_s[k]   <= 1'b0;
                r_sh[k]  <= '0;
                r_tag[k] <= '0;
                r_vld[k] <= 1'b0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < ShiftWidth; k++) begin
                r_v[k]   <= w_nv[k];
                r_s[k]   <= w_ns[k];
                r_sh[k]  <= w_nsh[k];
                r_tag[k] <= w_ntag[k];
                r_vld[k] <= w_nvld[k];
            end
        end
    end

    assign bus.valid_o  = r_vld[ShiftWidth-1];
    assign bus.data_o   = r_v[ShiftWidth-1][W-1:2];
    assign bus.guard_o  = r_v[ShiftWidth-1][1];
    assign bus.round_o  = r_v[ShiftWidth-1][0];
    assign bus.sticky_o = r_s[ShiftWidth-1];
    assign bus.tag_o    = r_tag[ShiftWidth-1];
endmodule

// File: tb/tb_align_shifter.sv
// Directed and random bench for align_shifter.
// Expected values come from hand tables and a wide-shift model.
module tb_align_shifter;
    typedef struct packed {
        logic [3:0]  tag;
        logic [23:0] data;
        logic        g;
        logic        r;
        logic        s;
    } res_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b1;
    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    res_t got_q[$];

    always #5 clk = ~clk;

    align_shifter_if bus ();

    align_shifter dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    function automatic res_t model(input logic [23:0] d,
                                   input logic [4:0] sh,
                                   input logic [3:0] t);
        logic [57:0] full;
        int          amt;
        res_t        r;
        amt    = (sh > 5'd26) ? 26 : int'(sh);
        full   = {d, 2'b00, 32'h0} >> amt;
        r.tag  = t;
        r.data = full[57:34];
        r.g    = full[33];
        r.r    = full[32];
        r.s    = |full[31:0];
        return r;
    endfunction

    function automatic res_t obs();
        res_t r;
        r = {bus.tag_o, bus.data_o, bus.guard_o, bus.round_o, bus.sticky_o};
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_ni === 1'b1) begin
            if (bus.valid_i && bus.ready_o)
                exp_q.push_back(model(bus.data_i, bus.shift_amount_i, bus.tag_i));
            if (bus.valid_o && bus.ready_i)
                got_q.push_back(obs());
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic send(input logic [23:0] d, input logic [4:0] sh,
                        input logic [3:0] t, output bit ok);
        bus.valid_i        = 1'b1;
        bus.data_i         = d;
        bus.shift_amount_i = sh;
        bus.tag_i          = t;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.ready_o) ok = 1'b1;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        bus.valid_i = 1'b0;
    endtask

    task automatic single(input logic [23:0] d, input logic [4:0] sh,
                          input logic [3:0] t, output res_t r,
                          output int lat);
        bit ok;
        bus.ready_i = 1'b1;
        r = '0;
        send(d, sh, t, ok);
        lat = 1;
        if (!ok) begin
            lat = -1;
            return;
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.valid_o) begin
                r = obs();
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        lat = -1;
    endtask

    task automatic test_reset;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        bus.data_i = '0;
        bus.shift_amount_i = '0;
        bus.tag_i = '0;
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if (obs() !== '0 || bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_init got out=%h v=%b rdy=%b want 0/0/1",
                     obs(), bus.valid_o, bus.ready_o);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (bus.valid_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle[%0d] valid_o=%b want 0", i, bus.valid_o);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midstream;
        bit ok;
        bus.ready_i = 1'b1;
        send(24'hABCDEF, 5'd3, 4'h1, ok);
        send(24'h123456, 5'd0, 4'h2, ok);
        send(24'hFFFFFF, 5'd7, 4'h3, ok);
        send(24'h800000, 5'd1, 4'h4, ok);
        rst_ni = 1'b0;
        bus.ready_i = 1'b0;
        #1;
        checks++;
        if (obs() !== '0 || bus.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_out got v=%b out=%h want 0/0",
                     bus.valid_o, obs());
        end
        checks++;
        if (bus.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_ready got %b want 1", bus.ready_o);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        bus.ready_i = 1'b1;
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (bus.valid_o !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_idle[%0d] valid_o=%b want 0",
                         i, bus.valid_o);
            end
        end
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_leak got %0d results want 0", got_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        logic [23:0] d_t [2] = '{24'h800000, 24'h800001};
        logic [4:0]  s_t [2] = '{5'd0, 5'd1};
        logic [23:0] e_d [2] = '{24'h800000, 24'h400000};
        logic [2:0]  e_f [2] = '{3'b000, 3'b100};
        res_t r;
        int   lat;
        for (int i = 0; i < 2; i++) begin
            single(d_t[i], s_t[i], 4'(i + 5), r, lat);
            checks++;
            if (r !== {4'(i + 5), e_d[i], e_f[i]}) begin
                errors++;
                $display("FAIL basic[%0d] got %h want %h", i, r,
                         {4'(i + 5), e_d[i], e_f[i]});
            end
            checks++;
            if (lat != 5) begin
                errors++;
                $display("FAIL basic_lat[%0d] got %0d want 5", i, lat);
            end
        end
    endtask

    task automatic test_sticky;
        logic [23:0] d_t [2] = '{24'h00000F, 24'h000010};
        logic [23:0] e_d [2] = '{24'h000001, 24'h000002};
        logic [2:0]  e_f [2] = '{3'b111, 3'b000};
        res_t r;
        int   lat;
        for (int i = 0; i < 2; i++) begin
            single(d_t[i], 5'd3, 4'hA, r, lat);
            checks++;
            if (r !== {4'hA, e_d[i], e_f[i]}) begin
                errors++;
                $display("FAIL sticky[%0d] got %h want %h", i, r,
                         {4'hA, e_d[i], e_f[i]});
            end
        end
    endtask

    task automatic test_large;
        logic [23:0] d_t [4] = '{24'h800000, 24'hFFFFFF, 24'hFFFFFF, 24'h000000};
        logic [4:0]  s_t [4] = '{5'd25, 5'd26, 5'd31, 5'd31};
        logic [2:0]  e_f [4] = '{3'b010, 3'b001, 3'b001, 3'b000};
        res_t r;
        int   lat;
        for (int i = 0; i < 4; i++) begin
            single(d_t[i], s_t[i], 4'hC, r, lat);
            checks++;
            if (r !== {4'hC, 24'h0, e_f[i]}) begin
                errors++;
                $display("FAIL large[%0d] got %h want %h", i, r,
                         {4'hC, 24'h0, e_f[i]});
            end
        end
    endtask

    task automatic test_backpressure;
        res_t snap;
        exp_q.delete();
        got_q.delete();
        bus.ready_i = 1'b0;
        fork
            begin
                bit ok;
                for (int i = 0; i < 8; i++) begin
                    send(24'($urandom), 5'($urandom_range(0, 31)), 4'(i), ok);
                    checks++;
                    if (!ok) begin
                        errors++;
                        $display("FAIL bp_send[%0d] not accepted", i);
                    end
                end
            end
            begin
                int n;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!bus.valid_o && n < 100);
                checks++;
                if (bus.valid_o !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_fill valid_o=%b want 1", bus.valid_o);
                end
                snap = obs();
                for (int j = 0; j < 3; j++) begin
                    checks++;
                    if (bus.ready_o !== 1'b0 || bus.valid_o !== 1'b1 ||
                        obs() !== snap) begin
                        errors++;
                        $display("FAIL bp_hold[%0d] rdy=%b v=%b out=%h want 0/1/%h",
                                 j, bus.ready_o, bus.valid_o, obs(), snap);
                    end
                    if (j < 2) begin
                        @(posedge clk);
                        #1;
                        @(negedge clk);
                    end
                end
                @(posedge clk);
                #1;
                bus.ready_i = 1'b1;
            end
        join
        for (int n = 0; n < 200 && got_q.size() < 8; n++) @(negedge clk);
        repeat (10) @(negedge clk);
        checks++;
        if (got_q.size() != 8 || exp_q.size() != 8) begin
            errors++;
            $display("FAIL bp_count got %0d exp %0d want 8",
                     got_q.size(), exp_q.size());
        end
        for (int i = 0; i < 8 && i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_q[i].tag !== 4'(i)) begin
                errors++;
                $display("FAIL bp_item[%0d] got %h want %h tag %0d",
                         i, got_q[i], exp_q[i], i);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_soak;
        int shown;
        exp_q.delete();
        got_q.delete();
        for (int c = 0; c < 60000 && exp_q.size() < 10000; c++) begin
            bus.valid_i        = ($urandom_range(0, 9) < 7);
            bus.ready_i        = ($urandom_range(0, 9) < 7);
            bus.data_i         = 24'($urandom);
            bus.shift_amount_i = 5'($urandom_range(0, 31));
            bus.tag_i          = 4'($urandom);
            @(posedge clk);
            #1;
        end
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        for (int n = 0; n < 200 && got_q.size() < exp_q.size(); n++)
            @(negedge clk);
        checks++;
        if (got_q.size() != exp_q.size() || exp_q.size() < 10000) begin
            errors++;
            $display("FAIL soak_count got %0d exp %0d",
                     got_q.size(), exp_q.size());
        end
        shown = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            res_t g;
            res_t e;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                if (shown < 10)
                    $display("FAIL soak_item got %h want %h", g, e);
                shown++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sticky();
        test_large();
        test_backpressure();
        test_reset_midstream();
        test_soak();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
